// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path.
//   - FSM state encoding of the fetch controller (S_BOOT, S_REQ, S_STALL)
//   - INSTR_BYTES: size of one instruction, the sequential PC increment
//   - RESET_PC_DEFAULT: default first fetch address after reset
//   - word_align(): clears the byte-offset bits of an address
package mips_pkg;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  localparam int          INSTR_BYTES      = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [29:0] word_addr);
    return {word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request bus between the fetch unit and instruction memory.
//   imem_req   : request valid (driven by master)
//   imem_addr  : request address, stable while imem_req=1 (driven by master)
//   imem_ready : memory accepts the request this cycle (driven by slave)
// A request is accepted in any cycle where imem_req & imem_ready.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;

  modport master (output imem_req, output imem_addr, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_ready);
endinterface

// File: rtl/pc_target_mux.sv
// Combinational redirect-target generator for the fetch stage.
// Computes the branch, jump and jump-register targets and selects one with
// priority jump_reg > jump > branch_taken. All arithmetic wraps mod 2^32.
//   branch_taken  in  : conditional branch resolved taken
//   branch_base   in  : PC+4 of the branch/jump instruction
//   branch_offset in  : sign-extended immediate, already shifted left 2
//   jump          in  : j/jal
//   jump_index    in  : instr[25:0]
//   jump_reg      in  : jr/jalr
//   jr_word       in  : jr register value without its byte-offset bits
//   redir_valid   out : any redirect requested this cycle
//   redir_target  out : selected redirect target
module pc_target_mux
  import mips_pkg::*;
(
  input  logic        branch_taken,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jump_reg,
  input  logic [29:0] jr_word,
  output logic        redir_valid,
  output logic [31:0] redir_target
);

  logic signed [31:0] offset_s;
  logic        [31:0] br_target;
  logic        [31:0] j_target;
  logic        [31:0] jr_target_al;

  assign offset_s     = branch_offset;
  // Two's-complement add: a negative offset wraps below zero silently.
  assign br_target    = branch_base + $unsigned(offset_s);
  assign j_target     = {branch_base[31:28], jump_index, 2'b00};
  assign jr_target_al = word_align(jr_word);

  always_comb begin
    redir_valid  = jump_reg | jump | branch_taken;
    redir_target = br_target;
    if (jump_reg) begin
      redir_target = jr_target_al;
    end else if (jump) begin
      redir_target = j_target;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// MIPS fetch-stage program counter, next-PC selection and imem request FSM.
// Issues one request per PC; the PC advances only when a request is accepted.
// Redirects honour the delay slot: the fetch already accepted/in flight is
// delivered, and the redirect steers the following fetch.
//   clk, reset     : clock, synchronous active-high reset
//   stall          : downstream busy, blocks issue of further requests
//   branch_taken / branch_base / branch_offset : taken conditional branch
//   jump / jump_index     : j/jal
//   jump_reg / jr_target  : jr/jalr
//   imem (master)  : imem_req / imem_addr / imem_ready handshake
//   fetch_valid    : pulse the cycle after acceptance
//   fetch_pc/_pc4  : accepted address and address+4 (held otherwise)
//   misalign_fault : pulse the cycle after a jr with a misaligned target
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter bit          ALIGN_FAULT = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_base,
  input  logic [31:0]             branch_offset,
  input  logic                    jump,
  input  logic [25:0]             jump_index,
  input  logic                    jump_reg,
  input  logic [31:0]             jr_target,
  pc_fetch_unit_if.master         imem,
  output logic                    fetch_valid,
  output logic [31:0]             fetch_pc,
  output logic [31:0]             fetch_pc4,
  output logic                    misalign_fault
);

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        accepted;
  logic [31:0] next_pc;

  pc_target_mux u_target_mux (
    .branch_taken  (branch_taken),
    .branch_base   (branch_base),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .jr_word       (jr_target[31:2]),
    .redir_valid   (redir_valid),
    .redir_target  (redir_target)
  );

  // Moore request: address is the PC itself, so it cannot move while req=1.
  assign imem.imem_req  = (state == S_REQ);
  assign imem.imem_addr = pc;
  assign accepted       = (state == S_REQ) && imem.imem_ready;
  assign pc_plus4       = pc + 32'(INSTR_BYTES);

  // A same-cycle redirect beats an older pending one.
  always_comb begin
    next_pc = pc_plus4;
    if (redir_valid) begin
      next_pc = redir_target;
    end else if (pend_valid) begin
      next_pc = pend_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_BOOT;
      pc             <= RESET_PC;
      pend_valid     <= 1'b0;
      pend_target    <= '0;
      fetch_valid    <= 1'b0;
      fetch_pc       <= '0;
      fetch_pc4      <= '0;
      misalign_fault <= 1'b0;
    end else begin
      fetch_valid    <= accepted;
      misalign_fault <= ALIGN_FAULT && jump_reg && (jr_target[1:0] != 2'b00);

      case (state)
        S_BOOT:  state <= S_REQ;
        // stall only matters once the issued request has been accepted
        S_REQ:   if (accepted && stall) state <= S_STALL;
        S_STALL: if (!stall) state <= S_REQ;
        default: state <= S_BOOT;
      endcase

      if (accepted) begin
        pc          <= next_pc;
        pend_valid  <= 1'b0;
        fetch_pc    <= pc;
        fetch_pc4   <= pc_plus4;
      end else if (redir_valid) begin
        pend_valid  <= 1'b1;
        pend_target <= redir_target;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, jump_reg;
  logic [31:0] branch_base, branch_offset, jr_target;
  logic [25:0] jump_index;
  logic        fetch_valid, misalign_fault;
  logic [31:0] fetch_pc, fetch_pc4;

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_base    (branch_base),
    .branch_offset  (branch_offset),
    .jump           (jump),
    .jump_index     (jump_index),
    .jump_reg       (jump_reg),
    .jr_target      (jr_target),
    .imem           (bus),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_pc4      (fetch_pc4),
    .misalign_fault (misalign_fault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the fetch unit should be doing, in plain terms.
  logic [31:0] m_pc, m_pend_tgt, m_fpc, m_fpc4;
  bit          m_known = 0;     // model synchronised by a reset
  bit          m_waking, m_holding, m_pend, m_fv, m_mf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] tgt;
    bit          any, presenting, acc, was_holding;
    if (reset) begin
      m_known = 1; m_pc = 32'h0; m_waking = 1; m_holding = 0; m_pend = 0;
      m_fv = 0; m_fpc = 0; m_fpc4 = 0; m_mf = 0;
      return;
    end
    any = jump_reg || jump || branch_taken;
    if (jump_reg)  tgt = jr_target & 32'hFFFF_FFFC;
    else if (jump) tgt = (branch_base & 32'hF000_0000) | ({6'd0, jump_index} * 4);
    else           tgt = branch_base + branch_offset;
    presenting  = !m_waking && !m_holding;
    acc         = presenting && bus.imem_ready;
    was_holding = m_holding;
    m_mf = jump_reg && (jr_target % 4 != 0);
    m_fv = acc;
    if (acc) begin
      m_fpc  = m_pc;
      m_fpc4 = m_pc + 4;
      m_pc   = any ? tgt : (m_pend ? m_pend_tgt : m_pc + 4);
      m_pend = 0;
    end else if (any) begin
      m_pend = 1; m_pend_tgt = tgt;
    end
    if (m_waking)         m_waking = 0;
    else if (was_holding) m_holding = stall;
    else if (acc)         m_holding = stall;
  endtask

  // One clock: request-side outputs before the edge, registered outputs after.
  task automatic cycle();
    if (m_known) begin
      check("imem_req", {31'd0, bus.imem_req}, {31'd0, (!m_waking && !m_holding)});
      check("imem_addr", bus.imem_addr, m_pc);
    end
    model_step();
    @(posedge clk);
    #1;
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fv});
    check("fetch_pc", fetch_pc, m_fpc);
    check("fetch_pc4", fetch_pc4, m_fpc4);
    check("misalign_fault", {31'd0, misalign_fault}, {31'd0, m_mf});
    @(negedge clk);
  endtask

  task automatic clear_redirects();
    branch_taken = 0; jump = 0; jump_reg = 0;
  endtask

  initial begin
    reset = 1; stall = 0; bus.imem_ready = 0;
    branch_taken = 0; jump = 0; jump_reg = 0;
    branch_base = 0; branch_offset = 0; jump_index = 0; jr_target = 0;
    @(negedge clk);

    // reset state
    cycle();
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'd0);
    reset = 0; bus.imem_ready = 1;

    // 1: back-to-back sequential fetches
    cycle();
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", bus.imem_addr, 32'(i * 4));
      cycle();
      check("seq_valid", {31'd0, fetch_valid}, 32'd1);
      check("seq_pc4", fetch_pc4, 32'(i * 4 + 4));
    end

    // 2: memory not ready holds the address, no fetch delivered
    bus.imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("wait_addr", bus.imem_addr, 32'h10);
      check("wait_valid", {31'd0, fetch_valid}, 32'd0);
    end

    // 3: taken branch on the accepting cycle, negative offset wraps to 0
    bus.imem_ready = 1;
    branch_taken = 1; branch_base = 32'h10; branch_offset = 32'hFFFF_FFF0;
    cycle();
    clear_redirects();
    check("br_fetch_pc", fetch_pc, 32'h10);
    check("br_addr", bus.imem_addr, 32'h0);

    // 4: jump beats branch; jr beats both
    jump = 1; branch_taken = 1; branch_base = 32'h4000_0008; jump_index = 26'h40;
    cycle();
    check("j_addr", bus.imem_addr, 32'h4000_0100);
    jump_reg = 1; jump = 1; branch_taken = 1; jr_target = 32'h1234_5678;
    cycle();
    clear_redirects();
    check("jr_addr", bus.imem_addr, 32'h1234_5678);

    // 5: misaligned jr during a stall, applied after the delay-slot fetch
    stall = 1;
    cycle();
    jump_reg = 1; jr_target = 32'h0000_0203;
    cycle();
    clear_redirects();
    check("mis_fault", {31'd0, misalign_fault}, 32'd1);
    check("mis_req", {31'd0, bus.imem_req}, 32'd0);
    cycle();
    check("mis_pulse_end", {31'd0, misalign_fault}, 32'd0);
    stall = 0;
    cycle();
    cycle();
    check("slot_fetch_pc", fetch_pc, 32'h1234_567C);
    check("aligned_addr", bus.imem_addr, 32'h200);
    cycle();
    check("aligned_fetch_pc", fetch_pc, 32'h200);

    // 6: reset while a request is outstanding
    bus.imem_ready = 0;
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    check("rst_mid_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_mid_pc", bus.imem_addr, 32'h0);
    check("rst_mid_valid", {31'd0, fetch_valid}, 32'd0);
    cycle();
    check("rst_mid_valid2", {31'd0, fetch_valid}, 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom % 97) == 0;
      stall          = ($urandom % 4) == 0;
      bus.imem_ready = ($urandom % 3) != 0;
      branch_taken   = ($urandom % 7) == 0;
      jump           = ($urandom % 9) == 0;
      jump_reg       = ($urandom % 11) == 0;
      branch_base    = $urandom;
      branch_offset  = {{14{1'b0}}, 18'($urandom)} - 32'h0002_0000;
      jump_index     = 26'($urandom);
      jr_target      = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
